// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable thresholds, sticky error flags,
// synchronous flush, and registered or first-word-fall-through output. Define FIFO_PARITY_EN for per-word parity.
module fifo_sync_flags #(
    parameter int P_DATA_W   = 11,
    parameter int P_ADDR_W   = 8,
    parameter int P_AF_LEVEL = 2**P_ADDR_W - 4,
    parameter int P_AE_LEVEL = 4,
    parameter int P_FWFT     = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic [P_DATA_W-1:0] i_data,
    input  logic                i_write,
    input  logic                i_read,
    output logic [P_DATA_W-1:0] o_data,
    output logic                o_valid,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_almost_empty,
    output logic                o_almost_full,
    output logic [P_ADDR_W:0]   o_count,
    output logic                o_overflow,
    output logic                o_underflow,
    output logic                o_parity_err
);
    localparam int P_DEPTH = 2**P_ADDR_W;
`ifdef FIFO_PARITY_EN
    localparam int P_MEM_W = P_DATA_W + 1;
`else
    localparam int P_MEM_W = P_DATA_W;
`endif
    localparam logic [P_ADDR_W:0] LP_FULL = (P_ADDR_W+1)'(P_DEPTH);
    localparam logic [P_ADDR_W:0] LP_AF   = (P_ADDR_W+1)'(P_AF_LEVEL);
    localparam logic [P_ADDR_W:0] LP_AE   = (P_ADDR_W+1)'(P_AE_LEVEL);

    logic [P_MEM_W-1:0]  r_mem [P_DEPTH];
    logic [P_ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [P_ADDR_W:0]   r_count;
    logic                r_overflow, r_underflow;

    logic               w_rd_ok, w_wr_ok;
    logic [P_MEM_W-1:0] w_wr_word, w_rd_word;
    logic               w_par_bad;

    assign w_rd_ok   = i_read && (r_count != '0);
    assign w_wr_ok   = i_write && ((r_count != LP_FULL) || w_rd_ok);
    assign w_rd_word = r_mem[r_rd_addr];

`ifdef FIFO_PARITY_EN
    // Stored even parity bit makes the XOR over the whole stored word zero for a clean word.
    assign w_wr_word = {^i_data, i_data};
    assign w_par_bad = ^w_rd_word;
`else
    assign w_wr_word = i_data;
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_wr_ok && !i_clear)
            r_mem[r_wr_addr] <= w_wr_word;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_addr <= r_wr_addr + 1'b1;
            if (w_rd_ok) r_rd_addr <= r_rd_addr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_write && !w_wr_ok)         r_overflow  <= 1'b1;
            if (i_read && (r_count == '0))   r_underflow <= 1'b1;
        end
    end

    assign o_count        = r_count;
    assign o_empty        = (r_count == '0);
    assign o_full         = (r_count == LP_FULL);
    assign o_almost_empty = (r_count <= LP_AE);
    assign o_almost_full  = (r_count >= LP_AF);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

    generate
        if (P_FWFT != 0) begin : g_fwft
            assign o_data       = w_rd_word[P_DATA_W-1:0];
            assign o_valid      = !o_empty;
            assign o_parity_err = o_valid && w_par_bad;
        end else begin : g_reg
            logic [P_DATA_W-1:0] r_data;
            logic                r_valid, r_perr;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_perr  <= 1'b0;
                end else if (i_clear) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_perr  <= 1'b0;
                end else if (w_rd_ok) begin
                    r_data  <= w_rd_word[P_DATA_W-1:0];
                    r_valid <= 1'b1;
                    r_perr  <= w_par_bad;
                end else begin
                    r_valid <= 1'b0;
                    r_perr  <= 1'b0;
                end
            end

            assign o_data       = r_data;
            assign o_valid      = r_valid;
            assign o_parity_err = r_perr;
        end
    endgenerate
endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised single-clock FIFO; successor to the basic EDC buffering FIFO.
- Adds overflow/underflow protection, true full at DEPTH entries, occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
- Selectable output mode: registered output (standard) or first-word-fall-through.
- Sits between EDC pipeline stages where producer and consumer share i_clk.

Parameters:
- P_DATA_W, 11, data word width in bits (>=1).
- P_ADDR_W, 8, address width; depth P_DEPTH = 2**P_ADDR_W.
- P_AF_LEVEL, 2**P_ADDR_W-4, o_almost_full asserted when count >= this (1..P_DEPTH).
- P_AE_LEVEL, 4, o_almost_empty asserted when count <= this (0..P_DEPTH-1).
- P_FWFT, 0, 0 = registered output mode; 1 = first-word-fall-through mode.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous flush; empties FIFO and clears sticky flags.
- i_data  in  P_DATA_W  write data.
- i_write  in  1  write request.
- i_read  in  1  read request.
- o_data  out  P_DATA_W  read data.
- o_valid  out  1  o_data valid.
- o_empty  out  1  count == 0.
- o_full  out  1  count == P_DEPTH.
- o_almost_empty  out  1  count <= P_AE_LEVEL.
- o_almost_full  out  1  count >= P_AF_LEVEL.
- o_count  out  P_ADDR_W+1  current occupancy, 0..P_DEPTH.
- o_overflow  out  1  sticky: write attempted while full and not accepted.
- o_underflow  out  1  sticky: read attempted while empty.
- o_parity_err  out  1  parity error on read word (see Optional Feature).

Behaviour:
Storage and reset
- Storage: P_DEPTH x P_DATA_W register array, asynchronous read by rd_addr; memory contents not reset.
- Reset (async, i_reset=1): wr_addr=0, rd_addr=0, count=0, o_data=0, o_valid=0, o_overflow=0, o_underflow=0, o_parity_err=0.
- Reset output values: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0.
- i_clear (sync, priority over read/write): same register values as reset, taking effect at the next edge; the write in that cycle is discarded.

Accept rules, evaluated per cycle
- rd_ok = i_read && count != 0.
- wr_ok = i_write && (count != P_DEPTH || rd_ok).
- A full FIFO accepts a simultaneous read and write; count stays at P_DEPTH.
- An empty FIFO with simultaneous read and write accepts only the write; count becomes 1, and the word is not bypassed.

Addressing, count and flags
- Pointers advance by 1 on accept and wrap modulo P_DEPTH naturally.
- count +1 on wr_ok only, -1 on rd_ok only, unchanged otherwise. All status flags derive combinationally from the count register.
- o_overflow sets on i_write && !wr_ok. o_underflow sets on i_read && count==0. Both hold until reset or i_clear.

Output modes
- P_FWFT=0: on rd_ok, o_data <= mem[rd_addr] and o_valid <= 1 at the next edge; otherwise o_valid <= 0 and o_data holds. Read latency is 1 cycle.
- P_FWFT=1: o_data = mem[rd_addr] combinationally and o_valid = !o_empty. i_read acts as acknowledge/pop, and the head word is visible in the cycle after it is written.

Optional Feature:
- Macro: FIFO_PARITY_EN.
- Defined:
  - Storage width becomes P_DATA_W+1; the extra bit holds even parity (XOR of i_data) computed on write.
  - On read, the stored parity is recomputed against the stored data.
  - o_parity_err is aligned with o_data/o_valid: registered with o_data when P_FWFT=0, combinational when P_FWFT=1.
  - o_parity_err resets to 0 and is forced to 0 whenever o_valid=0.
- Not defined: no parity storage or logic; o_parity_err tied to 0 (port retained).

Test Plan:
- Reset mid-traffic: write 5 words, assert i_reset asynchronously between edges -> immediately o_count=0, o_empty=1, o_valid=0, o_overflow=0.
- Fill/wrap (P_ADDR_W=3, P_FWFT=0): write 0x001..0x008 -> o_full=1, o_count=8, o_almost_full at count 4 (P_AF_LEVEL=4). Write 0x009 -> rejected, o_overflow=1. Read 8 -> o_data 0x001..0x008, each 1 cycle after i_read.
- Full simultaneous R/W: at count=8, read+write 0x0AA same cycle -> count stays 8, no overflow; 0x0AA emerges after 0x002..0x008.
- Empty simultaneous R/W: at count 0, read+write 0x155 -> o_underflow=1, count=1, o_valid=0 next cycle. Next read -> o_data=0x155.
- FWFT (P_FWFT=1): write 0x3FF -> next cycle o_valid=1, o_data=0x3FF. Pulse i_read -> o_valid=0, o_empty=1. Then i_clear -> o_underflow/o_overflow cleared.
- FIFO_PARITY_EN: force-flip one stored data bit via hierarchical deposit -> o_parity_err=1 with that word only; clean words give 0.
